// File: rtl/somador_serial_param.sv
// Digit-serial adder/subtractor: one DIGITO-bit adder slice reused over LARGURA/DIGITO cycles,
// with valid/ready handshakes on both sides.
module somador_serial_param #(
    parameter int LARGURA = 16,
    parameter int DIGITO  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valido,
    output logic               in_pronto,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valido,
    input  logic               out_pronto,
    output logic [LARGURA-1:0] soma,
    output logic               carry_out,
    output logic               overflow
);

    localparam int PASSOS = LARGURA / DIGITO;
    localparam int CW     = (PASSOS > 1) ? $clog2(PASSOS) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(PASSOS - 1);

    if (LARGURA < 1 || DIGITO < 1 || (LARGURA % DIGITO) != 0) begin : g_param_chk
        $error("somador_serial_param: DIGITO must divide LARGURA exactly");
    end

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    estado_t            estado, prox_estado;
    logic [CW-1:0]      passo;
    logic               carry_q;
    logic [LARGURA-1:0] reg_a, reg_b, acc;

    logic [DIGITO-1:0]  dig_a, dig_b, dig_s;
    logic               dig_c, c_msb;
    logic [LARGURA-1:0] acc_prox;

    // One digit slice; carry into the digit MSB is recovered from the MSB sum bit.
    always_comb begin
        dig_a = reg_a[int'(passo)*DIGITO +: DIGITO];
        dig_b = reg_b[int'(passo)*DIGITO +: DIGITO];
        {dig_c, dig_s} = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGITO{1'b0}}, carry_q};
        c_msb = dig_a[DIGITO-1] ^ dig_b[DIGITO-1] ^ dig_s[DIGITO-1];
        acc_prox = acc;
        acc_prox[int'(passo)*DIGITO +: DIGITO] = dig_s;
    end

    always_comb begin
        prox_estado = estado;
        in_pronto   = 1'b0;
        out_valido  = 1'b0;
        unique case (estado)
            OCIOSO: begin
                in_pronto = 1'b1;
                if (in_valido) prox_estado = CALCULA;
            end
            CALCULA: begin
                if (passo == ULTIMO) prox_estado = PRONTO;
            end
            PRONTO: begin
                out_valido = 1'b1;
                if (out_pronto) prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            passo     <= '0;
            carry_q   <= 1'b0;
            soma      <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            estado <= prox_estado;
            case (estado)
                OCIOSO: begin
                    if (in_valido) begin
                        passo   <= '0;
                        carry_q <= sub ? ~cin : cin;
                    end
                end
                CALCULA: begin
                    carry_q <= dig_c;
                    passo   <= passo + 1'b1;
                    // soma is loaded only with the finished word
                    if (passo == ULTIMO) begin
                        soma      <= acc_prox;
                        carry_out <= dig_c;
                        overflow  <= c_msb ^ dig_c;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and partial-result storage needs no reset: every digit is rewritten per operation.
    always_ff @(posedge clk) begin
        if (estado == OCIOSO && in_valido) begin
            reg_a <= a;
            reg_b <= sub ? ~b : b;
        end
        if (estado == CALCULA) acc <= acc_prox;
    end

endmodule
